// File: rtl/jogo_estados_pkg.sv
// State codes for the round-based memory game controller.
// The datapath debug logic and the bench use the same names.
package jogo_estados_pkg;

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicia_rodada  = 4'h2,
    espera_jogada  = 4'h3,
    registra       = 4'h4,
    comparacao     = 4'h5,
    proxima_jogada = 4'h6,
    proxima_rodada = 4'h7,
    fim_acertou    = 4'hA,
    fim_timeout    = 4'hD,
    fim_errou      = 4'hE
  } estado_t;

  // Final states hold their result until a new start request.
  function automatic logic estado_final(input estado_t e);
    return (e == fim_acertou) || (e == fim_errou) || (e == fim_timeout);
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas.sv
// Round-based Moore controller: round k replays memory positions 0..k,
// ending in a hit, a miss or an inactivity timeout.
module unidade_controle_rodadas
  import jogo_estados_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  input  logic       inativo,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraInativo,
  output logic       contaInativo,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t proximo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= inicial;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = inicial;
    if (estado_final(estado)) begin
      proximo = iniciar ? preparacao : estado;
    end else begin
      case (estado)
        inicial:        proximo = iniciar ? preparacao : inicial;
        preparacao:     proximo = inicia_rodada;
        inicia_rodada:  proximo = espera_jogada;
        // A play arriving together with the timeout still counts.
        espera_jogada: begin
          if (jogada)       proximo = registra;
          else if (inativo) proximo = fim_timeout;
          else              proximo = espera_jogada;
        end
        registra:       proximo = comparacao;
        comparacao: begin
          if (!igual)                    proximo = fim_errou;
          else if (!enderecoIgualLimite) proximo = proxima_jogada;
          else if (fimL)                 proximo = fim_acertou;
          else                           proximo = proxima_rodada;
        end
        proxima_jogada: proximo = espera_jogada;
        proxima_rodada: proximo = inicia_rodada;
        default:        proximo = inicial;
      endcase
    end
  end

  always_comb begin
    zeraE        = 1'b0;
    contaE       = 1'b0;
    zeraL        = 1'b0;
    contaL       = 1'b0;
    zeraR        = 1'b0;
    registraR    = 1'b0;
    zeraInativo  = 1'b0;
    contaInativo = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    timeout      = 1'b0;
    pronto       = 1'b0;
    case (estado)
      preparacao: begin
        zeraE       = 1'b1;
        zeraL       = 1'b1;
        zeraR       = 1'b1;
        zeraInativo = 1'b1;
      end
      inicia_rodada: begin
        zeraE       = 1'b1;
        zeraInativo = 1'b1;
      end
      espera_jogada:  contaInativo = 1'b1;
      registra: begin
        registraR   = 1'b1;
        zeraInativo = 1'b1;
      end
      proxima_jogada: contaE = 1'b1;
      proxima_rodada: contaL = 1'b1;
      fim_acertou: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      fim_errou: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      fim_timeout: begin
        errou   = 1'b1;
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: doc/unidade_controle_rodadas.md
# unidade_controle_rodadas

Round-based control unit for the memory game: it sequences the game datapath so that round *k* requires the player to reproduce memory positions 0..k, growing by one position per round. It drives the address counter, the round-limit counter, the play register and the inactivity counter. It ends in a hit, a miss or an inactivity timeout. It sits beside the game datapath in the round-game top level and replaces the single-pass control unit. Its debug state code feeds a hexa7seg display.

## Interface
Parameters:
- none; fixed-function block, state encoding fixed below.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state `inicial`
- iniciar  in  1  start/restart request, level-sampled on rising edge
- jogada  in  1  one-cycle pulse from datapath edge detector: a play was made
- igual  in  1  registered play equals memory word at current address
- enderecoIgualLimite  in  1  address counter equals round-limit counter
- fimL  in  1  round-limit counter at last position (final round)
- inativo  in  1  inactivity counter reached its terminal value
- zeraE  out  1  clear address counter
- contaE  out  1  increment address counter
- zeraL  out  1  clear round-limit counter
- contaL  out  1  increment round-limit counter
- zeraR  out  1  clear play register
- registraR  out  1  load play register from chaves
- zeraInativo  out  1  clear inactivity counter
- contaInativo  out  1  enable inactivity counter
- acertou  out  1  game won
- errou  out  1  game lost (wrong play or timeout)
- timeout  out  1  loss was caused by inactivity
- pronto  out  1  game finished
- db_estado  out  4  current state code

## Operation
- Moore machine: all outputs decode from the state register only. In any state, outputs not listed are 0.
- States (code: name: asserted outputs -> transitions):
  - 0x0 `inicial`: none -> `preparacao` if iniciar
  - 0x1 `preparacao`: zeraE, zeraL, zeraR, zeraInativo -> `inicia_rodada`
  - 0x2 `inicia_rodada`: zeraE, zeraInativo -> `espera_jogada`
  - 0x3 `espera_jogada`: contaInativo -> `registra` if jogada; else `fim_timeout` if inativo; else stay
  - 0x4 `registra`: registraR, zeraInativo -> `comparacao`
  - 0x5 `comparacao`: none, with this priority:
    - -> `fim_errou` if !igual
    - -> `proxima_jogada` if !enderecoIgualLimite
    - -> `fim_acertou` if fimL
    - -> `proxima_rodada` otherwise
  - 0x6 `proxima_jogada`: contaE -> `espera_jogada`
  - 0x7 `proxima_rodada`: contaL -> `inicia_rodada`
  - 0xA `fim_acertou`: acertou, pronto -> `preparacao` if iniciar; else stay
  - 0xE `fim_errou`: errou, pronto -> `preparacao` if iniciar; else stay
  - 0xD `fim_timeout`: errou, timeout, pronto -> `preparacao` if iniciar; else stay
- Undefined codes (0x8, 0x9, 0xB, 0xC, 0xF) -> `inicial` on next edge.
- iniciar is ignored in every state except `inicial` and the three final states.

## Timing
- Reset: state = `inicial`, every output 0, db_estado = 0x0. Takes effect immediately, without waiting for a clock edge. Reset mid-game abandons the round; counters are cleared on the next `preparacao`.
- Start: iniciar high at edge n -> `preparacao` after n. Counters clear at edge n+1. `espera_jogada` is reached after edge n+2.
- Per play: jogada at edge m -> `registra` (m), `comparacao` (m+1), then the next state at m+2. igual is evaluated one cycle after registraR, so the register holds the new value by then.
- A play in a non-final round returns to `espera_jogada` 3 edges after jogada (via `proxima_jogada`). Closing a round takes 4 edges (via `proxima_rodada` and `inicia_rodada`).
- Simultaneous jogada and inativo in `espera_jogada`: jogada wins.
- jogada pulses outside `espera_jogada` are dropped.
- Inactivity counter is cleared on round start and after each registered play. It counts only while in `espera_jogada`.
- Final outputs are held until iniciar or reset.

## Structure
- Shared package/include `jogo_estados_pkg`: the 4-bit state code constants above. The datapath debug and the bench use the same names.
- No sub-module: one state register (async reset), one next-state decoder, one output decoder. db_estado drives the existing hexa7seg instance.

## Test plan
- Full win, 4-position memory (fimL at limit 3): correct plays 1+2+3+4 = 10 → acertou=1, pronto=1, db_estado=0xA. Exactly 3 contaL pulses are seen, and 6 contaE pulses.
- Wrong play in round 2 at position 1 (igual=0) → `fim_errou`, errou=1, timeout=0, pronto=1, db_estado=0xE. No further registraR.
- No jogada in round 1 until inativo rises → `fim_timeout`, errou=1, timeout=1, db_estado=0xD.
- jogada and inativo on the same edge in `espera_jogada` → `registra` (0x4), not timeout.
- Restart from `fim_errou` with iniciar → `preparacao` with zeraE, zeraL, zeraR, zeraInativo all 1 for one cycle.
- Reset asserted while in `comparacao` → outputs 0 and db_estado=0x0 before the next clock edge. The block stays in `inicial` until iniciar.
